// File: rtl/wr_resp_pkg.sv
// Shared types and helpers for the write-response scheduler and its arbiter.
package wr_resp_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        DELIVER = 1'b1
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Widest requester set the round-robin helper handles.
    localparam int RR_MAX = 8;
    localparam int RR_PW  = 3;

    typedef struct packed {
        logic             found;
        logic [RR_PW-1:0] idx;
    } rr_pick_t;

    // Rotate so ptr sits at offset 0, take the nearest set bit, unrotate back to an index.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [RR_PW-1:0]  ptr,
                                         input int                n);
        rr_pick_t r;
        int       pos;
        r = '0;
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            pos = int'(ptr) + i;
            if (pos >= n) pos = pos - n;
            if (i < n && valid[pos[RR_PW-1:0]]) begin
                r.found = 1'b1;
                r.idx   = pos[RR_PW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wr_resp_rr_sched_if.sv
// B-channel bundle between slave ports, the scheduler and master ports.
interface wr_resp_rr_sched_if #(
    parameter int NUM_SLAVES  = 4,
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = $clog2(NUM_MASTERS)
);
    import wr_resp_pkg::*;

    localparam int SW = $clog2(NUM_SLAVES);

    // Handshake: a transfer happens on a clock edge where valid and ready are both 1;
    // valid and its payload hold until that edge; ready may depend on valid, never the reverse.
    logic [NUM_SLAVES-1:0]      s_bvalid;
    logic [NUM_SLAVES*ID_W-1:0] s_bid;
    logic [NUM_SLAVES*2-1:0]    s_bresp;
    logic [NUM_SLAVES-1:0]      s_bready;
    logic [NUM_MASTERS-1:0]     m_bvalid;
    logic [ID_W-1:0]            m_bid;
    logic [1:0]                 m_bresp;
    logic [NUM_MASTERS-1:0]     m_bready;
    logic [SW-1:0]              grant_slave;
    logic                       busy;
    logic                       drop_err;
    state_t                     dbg_state;

    modport slave (
        input  s_bvalid, s_bid, s_bresp, m_bready,
        output s_bready, m_bvalid, m_bid, m_bresp, grant_slave, busy, drop_err, dbg_state
    );

    modport master (
        output s_bvalid, s_bid, s_bresp, m_bready,
        input  s_bready, m_bvalid, m_bid, m_bresp, grant_slave, busy, drop_err, dbg_state
    );

endinterface

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping at N.
module rr_arbiter_comb
    import wr_resp_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic          o_found,
    output logic [PW-1:0] o_idx
);

    rr_pick_t          w_pick;
    logic [RR_MAX-1:0] w_valid_ext;
    logic              w_unused_idx;

    assign w_valid_ext  = RR_MAX'(i_valid);
    assign w_pick       = rr_pick(w_valid_ext, RR_PW'(i_ptr), N);
    assign o_found      = w_pick.found;
    assign o_idx        = w_pick.idx[PW-1:0];
    assign w_unused_idx = ^w_pick.idx;

endmodule

// File: rtl/wr_resp_rr_sched.sv
// Round-robin B-channel scheduler: one buffered response, routed to the master named by BID.
module wr_resp_rr_sched
    import wr_resp_pkg::*;
#(
    parameter int NUM_SLAVES  = 4,
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = $clog2(NUM_MASTERS)
) (
    input logic               clk,
    input logic               rst,
    wr_resp_rr_sched_if.slave bus
);

    localparam int SW = $clog2(NUM_SLAVES);
    localparam logic [NUM_SLAVES-1:0]  S_ONE = NUM_SLAVES'(1);
    localparam logic [NUM_MASTERS-1:0] M_ONE = NUM_MASTERS'(1);

    state_t                 r_state, w_state_nxt;
    logic [SW-1:0]          r_rr_ptr, r_grant, w_sel;
    logic [ID_W-1:0]        r_bid, w_sel_bid;
    logic [1:0]             r_bresp, w_sel_bresp;
    logic                   r_drop, w_found, w_accept, w_bid_ok, w_m_hs;
    logic [NUM_MASTERS-1:0] w_m_target;

    rr_arbiter_comb #(.N(NUM_SLAVES)) u_arb (
        .i_valid (bus.s_bvalid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    assign w_sel_bid   = bus.s_bid[w_sel*ID_W +: ID_W];
    assign w_sel_bresp = bus.s_bresp[w_sel*2 +: 2];
    assign w_bid_ok    = 32'(w_sel_bid) < 32'(NUM_MASTERS);
    // Gated by rst so no slave sees ready while the block is held in reset.
    assign w_accept    = rst & (r_state == IDLE) & w_found;
    assign w_m_target  = (r_state == DELIVER) ? (M_ONE << r_bid) : '0;
    assign w_m_hs      = |(w_m_target & bus.m_bready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.s_bready = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    bus.s_bready = S_ONE << w_sel;
                    if (w_bid_ok) w_state_nxt = DELIVER;
                end
            end
            DELIVER: begin
                if (w_m_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_bid    <= '0;
            r_bresp  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_accept & ~w_bid_ok;
            if (w_accept) begin
                r_bid    <= w_sel_bid;
                r_bresp  <= w_sel_bresp;
                r_grant  <= w_sel;
                r_rr_ptr <= (32'(w_sel) == 32'(NUM_SLAVES - 1)) ? '0 : w_sel + SW'(1);
            end
        end
    end

    assign bus.m_bvalid    = w_m_target;
    assign bus.m_bid       = r_bid;
    assign bus.m_bresp     = r_bresp;
    assign bus.grant_slave = r_grant;
    assign bus.busy        = (r_state == DELIVER);
    assign bus.drop_err    = r_drop;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_wr_resp_rr_sched.sv
// Bench for wr_resp_rr_sched: directed scenarios plus random traffic against a cycle-level reference.
module tb_wr_resp_rr_sched;
    import wr_resp_pkg::*;

    localparam int NS  = 4;
    localparam int NM  = 2;
    localparam int IW  = 1;
    localparam int NM3 = 3;
    localparam int IW3 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wr_resp_rr_sched_if #(.NUM_SLAVES(NS), .NUM_MASTERS(NM),  .ID_W(IW))  bus  ();
    wr_resp_rr_sched_if #(.NUM_SLAVES(NS), .NUM_MASTERS(NM3), .ID_W(IW3)) bus3 ();

    wr_resp_rr_sched #(.NUM_SLAVES(NS), .NUM_MASTERS(NM), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_resp_rr_sched #(.NUM_SLAVES(NS), .NUM_MASTERS(NM3), .ID_W(IW3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [IW+1:0] exp_q[$];

    // Reference state: what the buffer holds and where the search starts.
    bit mdl_busy;
    bit mdl_drop;
    int mdl_ptr, mdl_grant, mdl_bid, mdl_bresp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model and per-cycle compare.
    initial begin : cmp
        int sel;
        logic [NS-1:0]  exp_sr;
        logic [NM-1:0]  exp_mv;
        logic [IW+1:0]  e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mdl_busy = 0; mdl_drop = 0; mdl_ptr = 0; mdl_grant = 0; mdl_bid = 0; mdl_bresp = 0;
                exp_q.delete();
            end
            sel = -1;
            if (rst && !mdl_busy)
                for (int i = 0; i < NS; i++)
                    if (sel < 0 && bus.s_bvalid[(mdl_ptr + i) % NS]) sel = (mdl_ptr + i) % NS;
            exp_sr = '0;
            if (sel >= 0) exp_sr[sel] = 1'b1;
            exp_mv = '0;
            if (mdl_busy) exp_mv[mdl_bid] = 1'b1;
            chk("s_bready", bus.s_bready, exp_sr);
            chk("m_bvalid", bus.m_bvalid, exp_mv);
            chk("m_bid", bus.m_bid, mdl_bid);
            chk("m_bresp", bus.m_bresp, mdl_bresp);
            chk("grant_slave", bus.grant_slave, mdl_grant);
            chk("busy", bus.busy, mdl_busy);
            chk("drop_err", bus.drop_err, mdl_drop);
            chk("state", bus.dbg_state, mdl_busy ? DELIVER : IDLE);
            if (rst) begin
                mdl_drop = 0;
                if (mdl_busy) begin
                    if (bus.m_bready[mdl_bid]) begin
                        chk("sb_nonempty", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("sb_bid", bus.m_bid, e[IW+1:2]);
                            chk("sb_bresp", bus.m_bresp, e[1:0]);
                        end
                        mdl_busy = 0;
                    end
                end else if (sel >= 0) begin
                    mdl_bid   = bus.s_bid[sel*IW +: IW];
                    mdl_bresp = bus.s_bresp[sel*2 +: 2];
                    mdl_grant = sel;
                    mdl_ptr   = (sel + 1) % NS;
                    if (mdl_bid < NM) begin
                        mdl_busy = 1;
                        exp_q.push_back({IW'(mdl_bid), 2'(mdl_bresp)});
                    end else begin
                        mdl_drop = 1;
                    end
                end
            end
        end
    end

    task automatic random_phase(input int cycles);
        logic [NS-1:0] hs;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            hs = bus.s_bvalid & bus.s_bready;
            cyc();
            for (int k = 0; k < NS; k++) begin
                if (hs[k] || !bus.s_bvalid[k]) begin
                    bus.s_bvalid[k]          = ($urandom_range(0, 2) != 0);
                    bus.s_bid[k*IW +: IW]    = IW'($urandom_range(0, NM - 1));
                    bus.s_bresp[k*2 +: 2]    = 2'($urandom_range(0, 3));
                end
            end
            bus.m_bready = NM'($urandom_range(0, (1 << NM) - 1));
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.s_bvalid = 4'b1111; bus.s_bid = '0; bus.s_bresp = '0; bus.m_bready = '0;
        bus3.s_bvalid = '0; bus3.s_bid = '0; bus3.s_bresp = '0; bus3.m_bready = '0;

        // Reset values, including no ready while held in reset.
        @(negedge clk);
        chk("rst_s_bready", bus.s_bready, 0);
        chk("rst_m_bvalid", bus.m_bvalid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant_slave, 0);
        chk("rst_drop", bus.drop_err, 0);
        cyc();
        rst = 1'b1;

        // Single response from slave 0 to master 1.
        bus.s_bvalid = 4'b0001; bus.s_bid = 4'b0001; bus.s_bresp = {6'b0, RESP_SLVERR};
        bus.m_bready = 2'b11;
        @(negedge clk);
        chk("single_s_bready", bus.s_bready, 4'b0001);
        cyc();
        bus.s_bvalid = '0;
        @(negedge clk);
        chk("single_m_bvalid", bus.m_bvalid, 2'b10);
        chk("single_m_bid", bus.m_bid, 1);
        chk("single_m_bresp", bus.m_bresp, 2'b10);
        cyc();
        @(negedge clk);
        chk("single_busy_clear", bus.busy, 0);
        cyc();

        // Reset while slave 2's response waits on a stalled master.
        bus.s_bvalid = 4'b0100; bus.s_bid = 4'b0100; bus.s_bresp = '0; bus.m_bready = 2'b00;
        @(negedge clk);
        chk("rstmid_s_bready", bus.s_bready, 4'b0100);
        cyc();
        bus.s_bvalid = '0;
        @(negedge clk);
        chk("rstmid_busy_before", bus.busy, 1);
        chk("rstmid_grant_before", bus.grant_slave, 2);
        chk("rstmid_m_bvalid_before", bus.m_bvalid, 2'b10);
        #2;
        rst = 1'b0;
        bus.s_bvalid = 4'b0001;
        #1;
        chk("rstmid_m_bvalid", bus.m_bvalid, 0);
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_s_bready", bus.s_bready, 0);
        cyc();
        cyc();
        rst = 1'b1;

        // All slaves valid continuously: grants rotate 0,1,2,3,0 from slave 0.
        bus.s_bvalid = 4'b1111; bus.s_bid = 4'b1010;
        bus.s_bresp  = {RESP_DECERR, RESP_SLVERR, RESP_EXOKAY, RESP_OKAY};
        bus.m_bready = 2'b11;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                chk("rr_s_bready", bus.s_bready, 1 << ((c / 2) % 4));
            end else begin
                chk("rr_grant", bus.grant_slave, (c / 2) % 4);
                chk("rr_m_bvalid", bus.m_bvalid, ((c / 2) % 2) ? 2'b10 : 2'b01);
                chk("rr_m_bresp", bus.m_bresp, (c / 2) % 4);
            end
            cyc();
        end
        bus.s_bvalid = '0;

        // Backpressure: slaves 1 and 3 valid, target master stalled for 5 cycles.
        bus.s_bvalid = 4'b1010; bus.s_bid = 4'b1000;
        bus.s_bresp  = {RESP_DECERR, 2'b00, RESP_EXOKAY, 2'b00};
        bus.m_bready = 2'b00;
        @(negedge clk);
        chk("bp_s_bready", bus.s_bready, 4'b0010);
        cyc();
        bus.s_bvalid = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_m_bvalid", bus.m_bvalid, 2'b01);
            chk("bp_m_bid", bus.m_bid, 0);
            chk("bp_m_bresp", bus.m_bresp, 2'b01);
            chk("bp_s_bready", bus.s_bready, 0);
            cyc();
        end
        bus.m_bready = 2'b11;
        @(negedge clk);
        chk("bp_release_m_bvalid", bus.m_bvalid, 2'b01);
        cyc();
        @(negedge clk);
        chk("bp_next_grant", bus.s_bready, 4'b1000);
        cyc();
        bus.s_bvalid = '0;
        @(negedge clk);
        chk("bp_next_m_bvalid", bus.m_bvalid, 2'b10);
        chk("bp_next_m_bresp", bus.m_bresp, 2'b11);
        cyc();

        // Ready from the non-target master must not complete the transfer.
        bus.s_bvalid = 4'b0001; bus.s_bid = 4'b0000; bus.s_bresp = {6'b0, RESP_SLVERR};
        bus.m_bready = 2'b10;
        @(negedge clk);
        chk("nt_s_bready", bus.s_bready, 4'b0001);
        cyc();
        bus.s_bvalid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("nt_m_bvalid", bus.m_bvalid, 2'b01);
            cyc();
        end
        bus.m_bready = 2'b01;
        @(negedge clk);
        chk("nt_m_bvalid_hs", bus.m_bvalid, 2'b01);
        cyc();
        @(negedge clk);
        chk("nt_busy_clear", bus.busy, 0);
        cyc();

        // Three-master build: BID 3 is dropped and the pointer still advances.
        bus3.s_bvalid = 4'b0001; bus3.s_bid = 8'h03; bus3.m_bready = 3'b111;
        @(negedge clk);
        chk("drop_s_bready", bus3.s_bready, 4'b0001);
        cyc();
        bus3.s_bvalid = 4'b0011; bus3.s_bid = 8'b0000_1000; bus3.s_bresp = 8'b0000_0100;
        @(negedge clk);
        chk("drop_err_pulse", bus3.drop_err, 1);
        chk("drop_m_bvalid", bus3.m_bvalid, 0);
        chk("drop_busy", bus3.busy, 0);
        chk("drop_ptr_next", bus3.s_bready, 4'b0010);
        cyc();
        bus3.s_bvalid = 4'b0001;
        @(negedge clk);
        chk("drop_err_clear", bus3.drop_err, 0);
        chk("drop_m3_bvalid", bus3.m_bvalid, 3'b100);
        chk("drop_m3_bid", bus3.m_bid, 2);
        chk("drop_m3_bresp", bus3.m_bresp, 1);
        cyc();
        @(negedge clk);
        chk("drop_wrap_s_bready", bus3.s_bready, 4'b0001);
        cyc();
        bus3.s_bvalid = '0;
        @(negedge clk);
        chk("drop_m3_bvalid0", bus3.m_bvalid, 3'b001);
        cyc();

        random_phase(600);

        // Drain: stop new traffic and bound the wait for the buffer to empty.
        bus.s_bvalid = '0;
        bus.m_bready = 2'b11;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        #1;
        chk("drain_busy", bus.busy, 0);
        chk("drain_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
